// File: rtl/i2s_dac_tx_pkg.sv
// Shared definitions for the I2S DAC transmitter: default sizes, the slot
// counter saturation limit, channel encoding and the slot-check arming states.
package i2s_pkg;

    localparam int WORD_W_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;

    // Slot counter width: one bit of headroom above a full slot so that an
    // over-long slot is still distinguishable from a correct one.
    function automatic int slot_cnt_w(input int word_w);
        return $clog2(word_w) + 1;
    endfunction

    // Saturation limit of the slot counter, 2^(clog2(word_w)+1)-1.
    function automatic int slot_cnt_max(input int word_w);
        return (1 << slot_cnt_w(word_w)) - 1;
    endfunction

    localparam int SLOT_CNT_MAX_DEF = slot_cnt_max(WORD_W_DEF);

    // Level of the synced word clock: low = left, high = right.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_t;

    // Slot-length check arming: the slot running out of reset is partial,
    // and so may be the one after a spurious edge caused by the synchroniser
    // reset value, so checking starts only once two edges have been seen.
    typedef enum logic [1:0] {
        ARM_OFF,
        ARM_HALF,
        ARM_ON
    } arm_t;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Codec/equaliser side signals of the I2S DAC transmitter. The master is the
// codec clock source plus equaliser; the slave is the transmitter.
interface i2s_dac_tx_if
    import i2s_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              bclk_in;
    logic              lrclk_in;
    logic [WORD_W-1:0] data_L_in;
    logic [WORD_W-1:0] data_R_in;
    logic              dac_sdata;
    logic              process_start;

    modport master (
        output bclk_in,
        output lrclk_in,
        output data_L_in,
        output data_R_in,
        input  dac_sdata,
        input  process_start
    );

    modport slave (
        input  bclk_in,
        input  lrclk_in,
        input  data_L_in,
        input  data_R_in,
        output dac_sdata,
        output process_start
    );
endinterface

// File: rtl/i2s_dac_tx_sync_edge_det.sv
// Brings an asynchronous codec clock into the clk domain through a flop chain
// and flags its rising and falling edges with one-clk pulses. STAGES must be
// at least 2.
module sync_edge_det
    import i2s_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one history flop for edge detection.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edges compare two registered samples, so the pulses are glitch-free and
    // appear STAGES clk after the pin changes.
    assign level = sync_q[STAGES-1];
    assign rise  =  level & ~prev_q;
    assign fall  = ~level &  prev_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter. Latches the equaliser's stereo result at each
// left-frame start, pulses process_start, and shifts the words out MSB-first
// with the I2S one-bit delay. A sticky flag reports slots that are not
// exactly WORD_W bit clocks long.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    i2s_dac_tx_if.slave     bus,
    input  logic            err_clr,
    output logic            slot_err
);
    localparam int                CNT_W   = slot_cnt_w(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(slot_cnt_max(WORD_W));
    localparam logic [CNT_W-1:0]  SLOT_OK = CNT_W'(WORD_W - 1);

    logic              bfall;
    logic              b_rise;
    logic              b_level;
    logic              lr_level;
    logic              lr_rise;
    logic              lrfall;
    logic              lrchg;
    chan_t             lr_chan;

    logic [WORD_W-1:0] hold_L;
    logic [WORD_W-1:0] hold_R;
    logic [WORD_W-1:0] sreg;
    logic              load_pend;
    logic              process_start_q;
    logic [CNT_W-1:0]  slot_cnt;
    arm_t              arm_q;
    arm_t              arm_d;
    logic              err_set;

    // Only the falling edge of the bit clock is used.
    logic              unused_bclk;
    assign unused_bclk = b_rise ^ b_level;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_det (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.bclk_in),
        .level   (b_level),
        .rise    (b_rise),
        .fall    (bfall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrclk_det (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.lrclk_in),
        .level   (lr_level),
        .rise    (lr_rise),
        .fall    (lrfall)
    );

    assign lrchg   = lr_rise | lrfall;
    assign lr_chan = chan_t'(lr_level);

    // Frame capture: both channels latched together at the left-slot start so
    // the pair stays coherent; process_start tells the equaliser to begin the
    // next sample, whose result is picked up one frame later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_L          <= '0;
            hold_R          <= '0;
            process_start_q <= 1'b0;
        end else begin
            process_start_q <= lrfall;
            if (lrfall) begin
                hold_L <= bus.data_L_in;
                hold_R <= bus.data_R_in;
            end
        end
    end

    // Shifter: the bit clock fall that coincides with a word-clock edge still
    // shifts (sending the previous word's LSB), and the new word loads on the
    // following fall, giving the I2S one-bit delay. Extra bits of a long slot
    // are zeros shifted in; a short slot simply cuts the word off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg      <= '0;
            load_pend <= 1'b0;
        end else begin
            if (bfall) begin
                if (load_pend && !lrchg) begin
                    sreg <= (lr_chan == RIGHT) ? hold_R : hold_L;
                end else begin
                    sreg <= {sreg[WORD_W-2:0], 1'b0};
                end
            end
            if (lrchg) begin
                load_pend <= 1'b1;
            end else if (bfall && load_pend) begin
                load_pend <= 1'b0;
            end
        end
    end

    // Slot length counter: bit-clock falls strictly between word-clock edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
        end else if (lrchg) begin
            slot_cnt <= '0;
        end else if (bfall && (slot_cnt != CNT_MAX)) begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Arming state register for the slot-length check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= ARM_OFF;
        end else begin
            arm_q <= arm_d;
        end
    end

    // Arming next state and the error-set decision at each word-clock edge.
    // NOTE: every output of a combinational block is defaulted first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        arm_d   = arm_q;
        err_set = 1'b0;
        if (lrchg) begin
            case (arm_q)
                ARM_OFF:  arm_d = ARM_HALF;
                ARM_HALF: arm_d = ARM_ON;
                default: begin
                    arm_d   = ARM_ON;
                    err_set = (slot_cnt != SLOT_OK);
                end
            endcase
        end
    end

    // Sticky error flag; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_err <= 1'b0;
        end else if (err_set) begin
            slot_err <= 1'b1;
        end else if (err_clr) begin
            slot_err <= 1'b0;
        end
    end

    assign bus.dac_sdata     = sreg[WORD_W-1];
    assign bus.process_start = process_start_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx. Bit and word clocks are driven slot by slot;
// each slot pushes its expected serial bits onto a queue, and every bit clock
// pops one and compares it with dac_sdata.
module tb_i2s_dac_tx;
    import i2s_pkg::*;

    localparam int WORD_W      = 32;
    localparam int SYNC_STAGES = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic err_clr = 1'b0;
    logic slot_err;

    i2s_dac_tx_if #(.WORD_W(WORD_W)) bus ();

    i2s_dac_tx #(.WORD_W(WORD_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .err_clr  (err_clr),
        .slot_err (slot_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state.
    bit          exp_q[$];
    logic        prev_bit;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    logic        cur_lr;
    int          arm_cnt;
    int          last_len;
    logic        exp_err;

    // process_start monitor.
    int   ps_high  = 0;
    int   ps_rises = 0;
    logic ps_prev  = 1'b0;

    always @(negedge clk) begin
        if (bus.process_start === 1'b1) ps_high++;
        if (bus.process_start === 1'b1 && ps_prev !== 1'b1) ps_rises++;
        ps_prev = bus.process_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One word-clock slot of n bit clocks on channel lr. Each period starts on
    // a bclk fall at time T (multiple of 50 ns, clk edges at 5 mod 10).
    // chg: new data applied 2 clk after process_start in period 0.
    // clr: err_clr pulse in period 1. rst_at: period in which reset is pulsed.
    task automatic send_slot(input int n, input logic lr, input bit chg,
                             input logic [31:0] nl, input logic [31:0] nr,
                             input bit clr, input int rst_at);
        logic [31:0] w;
        bit          e;
        bit          is_fall;
        is_fall = (cur_lr == 1'b1) && (lr == 1'b0);
        if (is_fall) begin
            exp_l = bus.data_L_in;
            exp_r = bus.data_R_in;
        end
        if (lr != cur_lr) begin
            if (arm_cnt >= 2 && last_len != WORD_W) exp_err = 1'b1;
            if (arm_cnt < 2) arm_cnt++;
        end
        last_len = n;
        w = (lr == 1'b1) ? exp_r : exp_l;
        for (int j = 1; j <= n; j++) begin
            exp_q.push_back((j <= WORD_W) ? w[WORD_W-j] : 1'b0);
        end
        cur_lr = lr;
        for (int i = 0; i < n; i++) begin
            bus.bclk_in = 1'b0;
            if (i == 0) bus.lrclk_in = lr;
            #20;
            check("sdata_hold", bus.dac_sdata, prev_bit);
            if (i == 0 && is_fall) check("ps_before", bus.process_start, 0);
            if (i == 1 && clr) begin
                err_clr = 1'b1;
                exp_err = 1'b0;
            end
            if (i == rst_at) begin
                #12 reset_n = 1'b0;
                #1;
                check("sdata_in_reset", bus.dac_sdata, 0);
                check("slot_err_in_reset", slot_err, 0);
                exp_q.delete();
                for (int k = 0; k < n - i; k++) exp_q.push_back(1'b0);
                prev_bit = 1'b0;
                exp_l    = '0;
                exp_r    = '0;
                arm_cnt  = 0;
                exp_err  = 1'b0;
                err_clr  = 1'b0;
                #9 reset_n = 1'b1;
                #8;
            end else begin
                #10;
                err_clr = 1'b0;
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 1, 0);
                    e = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                end
                check("sdata", bus.dac_sdata, e);
                prev_bit = e;
                if (i == 0 && is_fall) check("ps_pulse", bus.process_start, 1);
                #10;
                if (i == 0 && is_fall) check("ps_after", bus.process_start, 0);
                if (i == 0 && chg) begin
                    #5;
                    bus.data_L_in = nl;
                    bus.data_R_in = nr;
                    #5;
                end else begin
                    #10;
                end
            end
            bus.bclk_in = 1'b1;
            #50;
        end
        check("slot_err", slot_err, exp_err);
    endtask

    task automatic frame(input bit chg, input logic [31:0] nl, input logic [31:0] nr);
        send_slot(WORD_W, 1'b0, chg, nl, nr, 1'b0, -1);
        send_slot(WORD_W, 1'b1, 1'b0, '0, '0, 1'b0, -1);
    endtask

    int ps_rises0;
    int ps_high0;

    initial begin
        bus.bclk_in   = 1'b0;
        bus.lrclk_in  = 1'b0;
        bus.data_L_in = '0;
        bus.data_R_in = '0;
        exp_q.push_back(1'b0);
        prev_bit = 1'b0;
        exp_l    = '0;
        exp_r    = '0;
        cur_lr   = 1'b0;
        arm_cnt  = 0;
        last_len = 0;
        exp_err  = 1'b0;

        // Reset state.
        #33;
        check("rst_sdata", bus.dac_sdata, 0);
        check("rst_ps", bus.process_start, 0);
        check("rst_slot_err", slot_err, 0);
        #9 reset_n = 1'b1;
        #8 bus.bclk_in = 1'b1;
        #50;

        // Lead-in right slot, then frame 1 (zeros; equaliser result appears
        // after its process_start), frame 2 carries that result.
        send_slot(WORD_W, 1'b1, 1'b0, '0, '0, 1'b0, -1);
        frame(1'b1, 32'h8000_0001, 32'h7FFF_FFFE);
        frame(1'b0, '0, '0);

        // Data change after capture must wait for the next frame.
        frame(1'b1, 32'h1234_5678, 32'h7FFF_FFFE);
        frame(1'b0, '0, '0);

        // Ten frames with fresh data each time; count process_start pulses.
        ps_rises0 = ps_rises;
        ps_high0  = ps_high;
        for (int f = 0; f < 10; f++) begin
            frame(1'b1, $urandom, $urandom);
        end
        check("ps_pulse_count", ps_rises - ps_rises0, 10);
        check("ps_high_cycles", ps_high - ps_high0, 10);

        // Over-long left slot: trailing zeros and a sticky error, then clear.
        send_slot(34, 1'b0, 1'b0, '0, '0, 1'b0, -1);
        send_slot(WORD_W, 1'b1, 1'b0, '0, '0, 1'b0, -1);
        send_slot(WORD_W, 1'b0, 1'b0, '0, '0, 1'b1, -1);
        send_slot(WORD_W, 1'b1, 1'b0, '0, '0, 1'b0, -1);
        frame(1'b0, '0, '0);

        // Short right slot of all ones: truncated word and error.
        frame(1'b1, 32'hA5A5_0F0F, 32'hFFFF_FFFF);
        send_slot(WORD_W, 1'b0, 1'b0, '0, '0, 1'b0, -1);
        send_slot(30, 1'b1, 1'b0, '0, '0, 1'b0, -1);
        send_slot(WORD_W, 1'b0, 1'b0, '0, '0, 1'b0, -1);
        send_slot(WORD_W, 1'b1, 1'b0, '0, '0, 1'b1, -1);

        // Reset in the middle of a left word of ones, then recovery.
        frame(1'b1, 32'hFFFF_FFFF, 32'h0F0F_F0F0);
        send_slot(WORD_W, 1'b0, 1'b0, '0, '0, 1'b0, 5);
        send_slot(WORD_W, 1'b1, 1'b0, '0, '0, 1'b0, -1);
        frame(1'b0, '0, '0);
        frame(1'b1, 32'h1357_9BDF, 32'h2468_ACE0);
        frame(1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Serialises processed stereo audio to the DAC as a standard I2S stream. The block sits directly downstream of the IIR equaliser stage. The codec supplies `bclk` and `lrclk` as inputs, and this block also acts as the frame timing source for the equaliser. At each left-channel frame start it latches the equaliser's current L/R outputs, issues a one-cycle `process_start` pulse, and shifts the latched words out MSB-first with the I2S one-bit delay.

## Interface
- `WORD_W`, 32: bits per channel slot and per input word.
- `SYNC_STAGES`, 2: synchroniser depth for `bclk_in` and `lrclk_in`; minimum 2.
- `clk` in 1: system clock; frequency must be at least 8× the `bclk` frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `bclk_in` in 1: codec bit clock, asynchronous to `clk`.
- `lrclk_in` in 1: codec word clock; low = left, high = right.
- `data_L_in` in `WORD_W`: left sample from the equaliser, signed, left-justified.
- `data_R_in` in `WORD_W`: right sample from the equaliser.
- `err_clr` in 1: synchronous clear of `slot_err`.
- `dac_sdata` out 1: serial data to the DAC.
- `process_start` out 1: one-`clk` pulse marking the start of a frame.
- `slot_err` out 1: sticky slot-length error flag.

## Operation
- Both `bclk_in` and `lrclk_in` pass through `SYNC_STAGES` flops, followed by a registered edge detector.
  - `bfall` marks a synced `bclk` falling edge.
  - `lrfall` marks a synced `lrclk` falling edge.
  - `lrchg` marks a synced `lrclk` edge of either direction.
- On `lrfall`, `hold_L` and `hold_R` capture `data_L_in` and `data_R_in`, and `process_start` pulses for that same cycle.
  - Capture happens before the equaliser updates its outputs, so each frame carries the previous frame's result. End-to-end latency is therefore exactly one frame.
- Shifter behaviour on each `bfall`:
  - If `load_pend` is set, `sreg` loads `hold_L` (synced `lrclk` = 0) or `hold_R` (synced `lrclk` = 1), and `load_pend` clears.
  - Otherwise `sreg` shifts left by 1 and shifts in 0.
  - If `lrchg` coincides with `bfall`, the normal shift happens (driving the previous word's LSB) and `load_pend` is set.
  - `dac_sdata` always equals `sreg[WORD_W-1]`.
- If a slot is longer than `WORD_W` bclks, the extra bits are driven as 0. If it is shorter, the word is truncated.
- Slot check:
  - `slot_cnt` counts `bfall` events strictly between consecutive `lrchg` events and saturates at 2^(clog2(`WORD_W`)+1)-1.
  - At each `lrchg`, `slot_err` is set if `slot_cnt` ≠ `WORD_W`-1; `slot_cnt` then resets to 0.
  - The check is disarmed until the second `lrchg` after reset, since the first partial slot is ignored.
- `err_clr` clears `slot_err`. If `err_clr` and a new error occur in the same cycle, the set wins.

## Timing
- Reset values: `dac_sdata`=0, `process_start`=0, `slot_err`=0. Also `hold_L`/`hold_R`/`sreg`=0, `load_pend`=0, synchronisers=0, and the slot check is disarmed.
  - Output is silence until the first capture.
- `process_start` rises SYNC_STAGES+1 `clk` cycles after `lrclk_in` falls at the pin.
- `dac_sdata` changes SYNC_STAGES+1 `clk` cycles after a `bclk_in` fall. The MSB of each word appears one bclk after the `lrclk` transition, per I2S.
- Reset asserted mid-frame returns all state to reset values immediately. After release, the first `lrfall` restarts normal operation.
- Data inputs are sampled only on `lrfall`. Changes at any other time have no effect on the current frame.

## Structure
- Package `i2s_pkg` holds the `WORD_W` and `SYNC_STAGES` defaults, the saturation limit for `slot_cnt`, and the channel encoding (LEFT=0, RIGHT=1).
- Sub-module `sync_edge_det` (synchroniser, rise pulse, fall pulse) is instantiated twice, once for `bclk` and once for `lrclk`.

## Test plan
- Reset, then 64 bclk/frame with `data_L_in`=0x8000_0001 and `data_R_in`=0x7FFF_FFFE:
  - The first frame serialises zeros.
  - The second frame serialises L = 1,0×30,1 and R = 0,1×30,0, each MSB one bclk after the `lrclk` edge.
  - `slot_err` stays 0.
- Change `data_L_in` 2 clk after a `process_start` → the new value does not appear until the next frame's capture.
- Count `process_start` over 10 frames → exactly 10 single-cycle pulses, each SYNC_STAGES+1 clk after the `lrclk_in` fall.
- Drive a 34-bclk slot → the last 2 bits of that slot are 0 and `slot_err` goes to 1. Pulse `err_clr` → `slot_err` returns to 0 and stays there on following correct 32-bclk slots.
- Drive a 30-bclk right slot with `data_R_in`=0xFFFF_FFFF → 30 ones are sent and `slot_err`=1.
- Assert `reset_n` low mid-word → `dac_sdata` is 0 immediately. After release, the first partial slot does not set `slot_err`, and a correct stream resumes one frame later.
